// File: rtl/agu_pkg.sv
// -----------------------------------------------------------------------------
// agu_pkg
//   Shared types for the AGU fetch responder.
//   - mem_id_e      : memory space tag carried by every AGU beat
//   - beat_kind_e   : what the responder does with an accepted beat
//   - fetch_entry_t : one output queue entry {data, id, addr, is_pad}
//   - classify_beat : maps {mem_id, mem_is_null} to a beat_kind_e
// -----------------------------------------------------------------------------
package agu_pkg;

  localparam int AGU_ADDR_WIDTH = 32;
  localparam int AGU_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ID_ACT = 2'b00,
    ID_KER = 2'b01,
    ID_OUT = 2'b10,
    ID_RSV = 2'b11
  } mem_id_e;

  typedef enum logic [1:0] {
    KIND_READ  = 2'b00,  // SRAM read, data captured one cycle later
    KIND_PAD   = 2'b01,  // zero padding, no memory access
    KIND_TOKEN = 2'b10   // writeback address token, no memory access
  } beat_kind_e;

  typedef struct packed {
    logic [AGU_DATA_WIDTH-1:0] data;
    mem_id_e                   id;
    logic [AGU_ADDR_WIDTH-1:0] addr;
    logic                      is_pad;
  } fetch_entry_t;

  // Output-space beats never touch SRAM and are never padding, even if the
  // AGU happens to flag them as null.
  function automatic beat_kind_e classify_beat(input mem_id_e id, input logic is_null);
    beat_kind_e kind;
    if (id == ID_OUT) begin
      kind = KIND_TOKEN;
    end else if (is_null) begin
      kind = KIND_PAD;
    end else begin
      kind = KIND_READ;
    end
    return kind;
  endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// -----------------------------------------------------------------------------
// fetch_sync_fifo
//   Register-based synchronous FIFO of fetch_entry_t with a registered
//   occupancy count. A push is accepted when full only if a pop happens in
//   the same cycle, so push+pop at full keeps occupancy unchanged.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     push        : write push_entry this cycle
//     push_entry  : entry to write
//     pop         : consumer takes the head entry this cycle
//     head        : current head entry (stale when empty)
//     full, empty : status flags
//     count       : number of stored entries (log2(DEPTH)+1 bits)
// -----------------------------------------------------------------------------
module fetch_sync_fifo
  import agu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  // Pointers are power-of-two wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // slots are live, and the top masks the head while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/agu_fetch_responder.sv
// -----------------------------------------------------------------------------
// agu_fetch_responder
//   Responder end of the AGU address stream. Pulls beats with read_req,
//   turns each accepted beat into an SRAM read, a zero-pad entry or a
//   writeback address token, and queues results in acceptance order for the
//   PE-array feed / writeback unit. Credit-based flow control toward the AGU.
//   Ports:
//     clk, rst                    : clock, synchronous active-high reset
//     read_req                    : request next AGU beat (registered)
//     mem_addr/mem_id/mem_valid/
//     mem_is_null                 : AGU beat
//     sram_en/sram_bank/sram_addr : combinational SRAM read request
//     sram_rdata                  : SRAM data, one cycle after sram_en
//     out_valid/out_ready         : output handshake
//     out_data/out_id/out_addr/
//     out_is_pad                  : head entry of the output queue
//     busy                        : queue non-empty or beat in flight
//     err_overflow                : sticky, beat arrived with no credit
//     err_bad_id                  : sticky, beat with reserved mem_id
// -----------------------------------------------------------------------------
module agu_fetch_responder
  import agu_pkg::*;
#(
  parameter int ADDR_WIDTH = AGU_ADDR_WIDTH,
  parameter int DATA_WIDTH = AGU_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  read_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_id,
  input  logic                  mem_valid,
  input  logic                  mem_is_null,
  output logic                  sram_en,
  output logic [1:0]            sram_bank,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_id,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_is_pad,
  output logic                  busy,
  output logic                  err_overflow,
  output logic                  err_bad_id
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // One extra bit so credit arithmetic never wraps in intermediate terms.
  localparam int CR_W  = CNT_W + 1;
  localparam logic [CR_W-1:0] DEPTH_CR = CR_W'(FIFO_DEPTH);
  localparam logic [CR_W-1:0] SKID_CR  = CR_W'(SKID);

  // ---------------------------------------------------------------------------
  // Beat classification
  // ---------------------------------------------------------------------------
  mem_id_e    beat_id;
  beat_kind_e beat_kind;
  logic       beat_seen;
  logic       beat_bad;
  logic       beat_ok;
  logic       beat_ovf;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;

  logic             inflight_q;
  mem_id_e          inflight_id_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  beat_kind_e       inflight_kind_q;

  logic [CR_W-1:0]  credits_free;
  logic [CR_W-1:0]  occ_next;
  logic [CR_W-1:0]  credits_next;

  assign beat_id   = mem_id_e'(mem_id);
  assign beat_kind = classify_beat(beat_id, mem_is_null);

  // The AGU side has no ready: every valid beat outside reset is looked at.
  // Reserved-id beats are rejected before credits are considered, so they
  // never consume a credit and never count as an overflow.
  assign beat_seen = mem_valid && !rst;
  assign beat_bad  = beat_seen && (beat_id == ID_RSV);
  assign beat_ok   = beat_seen && !beat_bad && (credits_free != '0);
  assign beat_ovf  = beat_seen && !beat_bad && (credits_free == '0);

  // ---------------------------------------------------------------------------
  // SRAM request: combinational in the acceptance cycle
  // ---------------------------------------------------------------------------
  assign sram_en   = beat_ok && (beat_kind == KIND_READ);
  assign sram_bank = sram_en ? mem_id   : 2'b00;
  assign sram_addr = sram_en ? mem_addr : '0;

  // ---------------------------------------------------------------------------
  // In-flight stage: every accepted beat spends exactly one cycle here so that
  // reads (waiting for sram_rdata) and non-reads stay in acceptance order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_id_q   <= ID_ACT;
      inflight_addr_q <= '0;
      inflight_kind_q <= KIND_READ;
    end else begin
      inflight_q <= beat_ok;
      if (beat_ok) begin
        inflight_id_q   <= beat_id;
        inflight_addr_q <= mem_addr;
        inflight_kind_q <= beat_kind;
      end
    end
  end

  // NOTE: every field gets a value on every path through this block, so no
  // latch is inferred for push_entry.
  always_comb begin
    push_entry        = '0;
    push_entry.id     = inflight_id_q;
    push_entry.addr   = inflight_addr_q;
    push_entry.is_pad = (inflight_kind_q == KIND_PAD);
    if (inflight_kind_q == KIND_READ) begin
      push_entry.data = sram_rdata;
    end
  end

  // Credits guarantee room for the in-flight beat; the full guard only
  // protects the queue if that invariant were ever broken.
  assign fifo_pop  = out_ready && !fifo_empty;
  assign fifo_push = inflight_q && (!fifo_full || fifo_pop);

  fetch_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Credits and read_req
  //   credits_free counts slots not yet claimed by a queued or in-flight beat.
  //   read_req is registered from the post-edge credit count, so the only
  //   unaccounted beat is the one the AGU sends in response to the current
  //   read_req; SKID credits are held back for exactly that beat.
  // ---------------------------------------------------------------------------
  assign credits_free = DEPTH_CR - CR_W'(fifo_count) - CR_W'(inflight_q);
  assign occ_next     = CR_W'(fifo_count) + CR_W'(fifo_push) - CR_W'(fifo_pop);
  assign credits_next = DEPTH_CR - occ_next - CR_W'(beat_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      read_req <= 1'b0;
    end else begin
      read_req <= (credits_next > SKID_CR);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
      err_bad_id   <= 1'b0;
    end else begin
      if (beat_ovf) err_overflow <= 1'b1;
      if (beat_bad) err_bad_id   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output side: head fields are forced to zero while the queue is empty so
  // the unreset storage never leaks onto the ports.
  // ---------------------------------------------------------------------------
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0   : fifo_head.data;
  assign out_id     = fifo_empty ? 2'b00 : fifo_head.id;
  assign out_addr   = fifo_empty ? '0   : fifo_head.addr;
  assign out_is_pad = !fifo_empty && fifo_head.is_pad;
  assign busy       = !fifo_empty || inflight_q;

endmodule

// File: tb/tb_agu_fetch_responder.sv
module tb_agu_fetch_responder;

  localparam int DEPTH = 4;
  localparam int SKID  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_req;
  logic [31:0] mem_addr;
  logic [1:0]  mem_id;
  logic        mem_valid;
  logic        mem_is_null;
  logic        sram_en;
  logic [1:0]  sram_bank;
  logic [31:0] sram_addr;
  logic [31:0] sram_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_id;
  logic [31:0] out_addr;
  logic        out_is_pad;
  logic        busy;
  logic        err_overflow;
  logic        err_bad_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  agu_fetch_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (DEPTH),
    .SKID       (SKID)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .read_req     (read_req),
    .mem_addr     (mem_addr),
    .mem_id       (mem_id),
    .mem_valid    (mem_valid),
    .mem_is_null  (mem_is_null),
    .sram_en      (sram_en),
    .sram_bank    (sram_bank),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_id       (out_id),
    .out_addr     (out_addr),
    .out_is_pad   (out_is_pad),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_bad_id   (err_bad_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge: registered outputs
  // are settled, inputs for the new cycle can be driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid   = 1'b0;
    mem_id      = 2'b00;
    mem_addr    = '0;
    mem_is_null = 1'b0;
    out_ready   = 1'b0;
    sram_rdata  = '0;
  endtask

  task automatic drive_beat(input logic [1:0] id, input logic is_null, input logic [31:0] addr);
    mem_valid   = 1'b1;
    mem_id      = id;
    mem_is_null = is_null;
    mem_addr    = addr;
  endtask

  // Two reset cycles then release; returns in the 2nd cycle after release,
  // where read_req is already high on an empty queue.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " out_valid"},  64'(out_valid), 64'(0));
    check({tag, " out_data"},   64'(out_data), 64'(0));
    check({tag, " out_is_pad"}, 64'(out_is_pad), 64'(0));
    check({tag, " busy"},       64'(busy), 64'(0));
    check({tag, " err_ovf"},    64'(err_overflow), 64'(0));
    check({tag, " err_bad"},    64'(err_bad_id), 64'(0));
  endtask

  // Single-beat dispatch vectors.
  typedef struct {
    logic [1:0]  id;
    logic        is_null;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        exp_sram_en;
    logic        exp_out;
    logic [31:0] exp_data;
    logic        exp_pad;
  } vec_t;

  // Behavioural model entry: visible at ready_cycle, popped in order.
  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
    logic [31:0] addr;
    logic        pad;
    int          ready_cycle;
  } mentry_t;

  initial begin
    vec_t        vecs[7];
    logic [31:0] exp_data3[4];
    logic [1:0]  exp_id3[4];
    logic [31:0] exp_addr3[4];
    logic        exp_pad3[4];
    mentry_t     mq[$];
    mentry_t     me;
    logic        prev_rr;
    logic        exp_rr;
    logic        exp_ovf;
    logic        exp_bad;
    logic        exp_v;
    logic [31:0] cur_rdata;
    logic [31:0] nxt_rdata;
    int          credits;
    int          beats;
    logic        saw_rr_low;

    idle_inputs();
    rst = 1'b1;

    // ---- 1: reset ----------------------------------------------------------
    tick(); tick(); tick();
    check_idle_outputs("reset");
    check("reset read_req", 64'(read_req), 64'(0));
    check("reset sram_en", 64'(sram_en), 64'(0));
    rst = 1'b0;
    #1;
    check("release c1 read_req", 64'(read_req), 64'(0));
    tick();
    check("release c2 read_req", 64'(read_req), 64'(1));

    // ---- 2: single act read -------------------------------------------------
    drive_beat(2'b00, 1'b0, 32'h10);
    #1;
    check("t2 sram_en", 64'(sram_en), 64'(1));
    check("t2 sram_bank", 64'(sram_bank), 64'(0));
    check("t2 sram_addr", 64'(sram_addr), 64'(32'h10));
    tick();
    mem_valid  = 1'b0;
    sram_rdata = 32'hDEADBEEF;
    check("t2 t+1 out_valid", 64'(out_valid), 64'(0));
    check("t2 t+1 busy", 64'(busy), 64'(1));
    tick();
    sram_rdata = 32'h0;
    check("t2 t+2 out_valid", 64'(out_valid), 64'(1));
    check("t2 t+2 out_data", 64'(out_data), 64'(32'hDEADBEEF));
    check("t2 t+2 out_id", 64'(out_id), 64'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2 drained", 64'(out_valid), 64'(0));

    // ---- table-driven single-beat dispatch -----------------------------------
    vecs[0] = '{2'b00, 1'b0, 32'h0000_0100, 32'h1111_0001, 1'b1, 1'b1, 32'h1111_0001, 1'b0};
    vecs[1] = '{2'b01, 1'b0, 32'h0000_0204, 32'h2222_0002, 1'b1, 1'b1, 32'h2222_0002, 1'b0};
    vecs[2] = '{2'b00, 1'b1, 32'h0000_0308, 32'h3333_0003, 1'b0, 1'b1, 32'h0,         1'b1};
    vecs[3] = '{2'b01, 1'b1, 32'h0000_040C, 32'h4444_0004, 1'b0, 1'b1, 32'h0,         1'b1};
    vecs[4] = '{2'b10, 1'b0, 32'hFFFF_FFF0, 32'h5555_0005, 1'b0, 1'b1, 32'h0,         1'b0};
    vecs[5] = '{2'b10, 1'b1, 32'h0000_0500, 32'h6666_0006, 1'b0, 1'b1, 32'h0,         1'b0};
    vecs[6] = '{2'b11, 1'b0, 32'h0000_0600, 32'h7777_0007, 1'b0, 1'b0, 32'h0,         1'b0};
    for (int i = 0; i < 7; i++) begin
      drive_beat(vecs[i].id, vecs[i].is_null, vecs[i].addr);
      #1;
      check($sformatf("vec%0d sram_en", i), 64'(sram_en), 64'(vecs[i].exp_sram_en));
      tick();
      mem_valid  = 1'b0;
      sram_rdata = vecs[i].rdata;
      tick();
      sram_rdata = 32'h0;
      check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out));
      if (vecs[i].exp_out) begin
        check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
        check($sformatf("vec%0d out_id", i), 64'(out_id), 64'(vecs[i].id));
        check($sformatf("vec%0d out_addr", i), 64'(out_addr), 64'(vecs[i].addr));
        check($sformatf("vec%0d out_is_pad", i), 64'(out_is_pad), 64'(vecs[i].exp_pad));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("vec err_bad_id", 64'(err_bad_id), 64'(1));
    check("vec err_overflow", 64'(err_overflow), 64'(0));

    // ---- 3: mixed beats back-to-back ------------------------------------------
    do_reset();
    exp_data3 = '{32'hA000_0001, 32'h0, 32'hA000_0003, 32'h0};
    exp_id3   = '{2'b00, 2'b00, 2'b01, 2'b10};
    exp_addr3 = '{32'h1, 32'h2, 32'h3, 32'h40};
    exp_pad3  = '{1'b0, 1'b1, 1'b0, 1'b0};
    drive_beat(2'b00, 1'b0, 32'h1);
    #1; check("t3 act sram_en", 64'(sram_en), 64'(1));
    tick();
    drive_beat(2'b00, 1'b1, 32'h2);
    sram_rdata = 32'hA000_0001;
    #1; check("t3 null sram_en", 64'(sram_en), 64'(0));
    tick();
    drive_beat(2'b01, 1'b0, 32'h3);
    sram_rdata = 32'h5555_5555;
    #1;
    check("t3 ker sram_en", 64'(sram_en), 64'(1));
    check("t3 ker sram_bank", 64'(sram_bank), 64'(1));
    tick();
    drive_beat(2'b10, 1'b0, 32'h40);
    sram_rdata = 32'hA000_0003;
    #1; check("t3 out sram_en", 64'(sram_en), 64'(0));
    tick();
    mem_valid  = 1'b0;
    sram_rdata = 32'h6666_6666;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3 e%0d valid", k), 64'(out_valid), 64'(1));
      check($sformatf("t3 e%0d data", k), 64'(out_data), 64'(exp_data3[k]));
      check($sformatf("t3 e%0d id", k), 64'(out_id), 64'(exp_id3[k]));
      check($sformatf("t3 e%0d addr", k), 64'(out_addr), 64'(exp_addr3[k]));
      check($sformatf("t3 e%0d pad", k), 64'(out_is_pad), 64'(exp_pad3[k]));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("t3 empty after drain", 64'(out_valid), 64'(0));

    // ---- 4: AGU obeys read_req, consumer stalled -----------------------------
    do_reset();
    prev_rr    = 1'b0;
    beats      = 0;
    saw_rr_low = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (!read_req) saw_rr_low = 1'b1;
      if (prev_rr) begin
        drive_beat(2'b10, 1'b0, 32'h200 + 32'(beats));
        beats++;
      end else begin
        mem_valid = 1'b0;
      end
      prev_rr = read_req;
      tick();
    end
    mem_valid = 1'b0;
    check("t4 beats sent", 64'(beats), 64'(DEPTH));
    check("t4 read_req low", 64'(read_req), 64'(0));
    check("t4 read_req fell", 64'(saw_rr_low), 64'(1));
    check("t4 err_overflow", 64'(err_overflow), 64'(0));
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("t4 drain%0d valid", k), 64'(out_valid), 64'(1));
      check($sformatf("t4 drain%0d addr", k), 64'(out_addr), 64'(32'h200 + 32'(k)));
      tick();
    end
    out_ready = 1'b0;
    check("t4 empty after 4", 64'(out_valid), 64'(0));

    // ---- 5: forced overflow and reserved id -----------------------------------
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      drive_beat(2'b10, 1'b0, 32'h300 + 32'(k));
      tick();
    end
    drive_beat(2'b00, 1'b0, 32'h3FF);
    #1; check("t5 ovf sram_en", 64'(sram_en), 64'(0));
    tick();
    drive_beat(2'b11, 1'b0, 32'h3EE);
    check("t5 err_overflow set", 64'(err_overflow), 64'(1));
    check("t5 err_bad before", 64'(err_bad_id), 64'(0));
    tick();
    mem_valid = 1'b0;
    check("t5 err_bad_id set", 64'(err_bad_id), 64'(1));
    tick(); tick();
    check("t5 err_overflow sticky", 64'(err_overflow), 64'(1));
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("t5 drain%0d valid", k), 64'(out_valid), 64'(1));
      check($sformatf("t5 drain%0d addr", k), 64'(out_addr), 64'(32'h300 + 32'(k)));
      tick();
    end
    check("t5 dropped beats absent", 64'(out_valid), 64'(0));
    check("t5 err_bad sticky", 64'(err_bad_id), 64'(1));
    out_ready = 1'b0;

    // ---- 6: reset with 3 queued + 1 in flight --------------------------------
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_beat(2'b00, 1'b0, 32'h400 + 32'(k));
      sram_rdata = 32'hC000_0000 + 32'(k);
      tick();
    end
    mem_valid = 1'b0;
    check("t6 pre busy", 64'(busy), 64'(1));
    check("t6 pre out_valid", 64'(out_valid), 64'(1));
    rst        = 1'b1;
    sram_rdata = 32'hBAD0_BAD0;
    tick();
    rst = 1'b0;
    check_idle_outputs("t6 post");
    tick(); tick(); tick();
    check("t6 late rdata ignored", 64'(out_valid), 64'(0));
    check("t6 busy stays 0", 64'(busy), 64'(0));

    // ---- randomized run against the queue model ---------------------------------
    do_reset();
    mq.delete();
    exp_rr    = 1'b1;
    prev_rr   = 1'b0;
    exp_ovf   = 1'b0;
    exp_bad   = 1'b0;
    cur_rdata = $urandom;
    for (int c = 0; c < 3000; c++) begin
      exp_v = (mq.size() > 0) && (mq[0].ready_cycle <= c);
      check("rnd read_req", 64'(read_req), 64'(exp_rr));
      check("rnd busy", 64'(busy), 64'(mq.size() != 0));
      check("rnd out_valid", 64'(out_valid), 64'(exp_v));
      if (exp_v) begin
        check("rnd out_data", 64'(out_data), 64'(mq[0].data));
        check("rnd out_id", 64'(out_id), 64'(mq[0].id));
        check("rnd out_addr", 64'(out_addr), 64'(mq[0].addr));
        check("rnd out_is_pad", 64'(out_is_pad), 64'(mq[0].pad));
      end

      nxt_rdata   = $urandom;
      sram_rdata  = cur_rdata;
      mem_valid   = prev_rr && ($urandom_range(0, 3) != 0);
      mem_id      = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      mem_is_null = ($urandom_range(0, 3) == 0);
      mem_addr    = $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      credits     = DEPTH - mq.size();
      #1;
      check("rnd sram_en", 64'(sram_en),
            64'(mem_valid && mem_id != 2'b11 && credits > 0 && mem_id != 2'b10 && !mem_is_null));

      if (exp_v && out_ready) void'(mq.pop_front());
      if (mem_valid && mem_id == 2'b11) begin
        exp_bad = 1'b1;
      end else if (mem_valid && credits == 0) begin
        exp_ovf = 1'b1;
      end else if (mem_valid) begin
        me.id          = mem_id;
        me.addr        = mem_addr;
        me.pad         = (mem_id != 2'b10) && mem_is_null;
        me.data        = (mem_id != 2'b10 && !mem_is_null) ? nxt_rdata : 32'h0;
        me.ready_cycle = c + 2;
        mq.push_back(me);
      end
      prev_rr   = exp_rr;
      exp_rr    = (DEPTH - mq.size()) > SKID;
      cur_rdata = nxt_rdata;
      tick();
    end
    check("rnd err_overflow", 64'(err_overflow), 64'(exp_ovf));
    check("rnd err_bad_id", 64'(err_bad_id), 64'(exp_bad));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
